// File: rtl/spi_slave_param_if.sv
// ---------------------------------------------------------------------------
// spi_slave_param_if
//   Bundles the SPI pad signals and the downstream rx/tx handshake of
//   spi_slave_param so that the slave and its driver can share one port.
//
//   master modport : drives MOSI, SS_n, tx_data, tx_valid
//                    observes MISO, rx_valid, rx_data, frame_err, busy
//   slave modport  : the mirror image, used by spi_slave_param
// ---------------------------------------------------------------------------
interface spi_slave_param_if #(
    parameter int DATA_W = 8
);
    logic              MOSI;
    logic              SS_n;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              MISO;
    logic              rx_valid;
    logic [DATA_W+1:0] rx_data;
    logic              frame_err;
    logic              busy;

    modport master (
        output MOSI, SS_n, tx_data, tx_valid,
        input  MISO, rx_valid, rx_data, frame_err, busy
    );

    modport slave (
        input  MOSI, SS_n, tx_data, tx_valid,
        output MISO, rx_valid, rx_data, frame_err, busy
    );
endinterface

// File: rtl/spi_slave_param.sv
// ---------------------------------------------------------------------------
// spi_slave_param
//   SPI slave front end. Each frame is DATA_W+2 bits, MSB first: two command
//   bits followed by the payload. Complete frames are presented on rx_data
//   with a one-cycle rx_valid strobe. A read-data frame (command 11 once a
//   read-address frame has been seen) waits for tx_valid and then shifts
//   tx_data out on MISO, MSB first. clk is the SPI bit clock itself.
//
//   Ports
//     clk   : SPI bit clock, rising edge
//     rstn  : asynchronous active-low reset
//     bus   : slave modport of spi_slave_param_if
//             MOSI/SS_n in, tx_data/tx_valid in,
//             MISO, rx_valid, rx_data, frame_err, busy out
// ---------------------------------------------------------------------------
module spi_slave_param #(
    parameter  int DATA_W = 8,
    localparam int CNT_W  = $clog2(DATA_W + 3)
) (
    input  logic             clk,
    input  logic             rstn,
    spi_slave_param_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADDR,
        READ_DATA,
        TX_WAIT,
        TX_SHIFT,
        DONE
    } state_e;

    // Bit-count milestones: bits captured so far in a frame, bits sent in TX.
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST_RX = CNT_W'(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL    = CNT_W'(DATA_W + 2);
    localparam logic [CNT_W-1:0] CNT_LAST_TX = CNT_W'(DATA_W);

    state_e            state_q,        state_d;
    logic [CNT_W-1:0]  cnt_q,          cnt_d;
    // Holds the bits captured so far; the final bit comes straight from MOSI.
    logic [DATA_W:0]   shift_q,        shift_d;
    logic [DATA_W-1:0] tx_sh_q,        tx_sh_d;
    logic [DATA_W+1:0] rx_data_q,      rx_data_d;
    logic              rx_valid_q,     rx_valid_d;
    logic              frame_err_q,    frame_err_d;
    logic              miso_q,         miso_d;
    logic              rd_addr_seen_q, rd_addr_seen_d;

    always_comb begin
        // NOTE: every _d gets a default before the case, so no path can infer a latch.
        state_d        = state_q;
        cnt_d          = cnt_q;
        shift_d        = shift_q;
        tx_sh_d        = tx_sh_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        frame_err_d    = 1'b0;
        miso_d         = miso_q;
        rd_addr_seen_d = rd_addr_seen_q;

        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                miso_d = 1'b0;
                if (!bus.SS_n) state_d = CHK_CMD;
            end

            CHK_CMD: begin
                if (bus.SS_n) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                    miso_d      = 1'b0;
                end else begin
                    shift_d = {{DATA_W{1'b0}}, bus.MOSI};
                    cnt_d   = CNT_ONE;
                    // Only the first command bit is known here, so read
                    // address vs read data is steered by the history flag.
                    if (!bus.MOSI)          state_d = WRITE;
                    else if (rd_addr_seen_q) state_d = READ_DATA;
                    else                     state_d = READ_ADDR;
                end
            end

            WRITE, READ_ADDR, READ_DATA: begin
                if (bus.SS_n) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                    miso_d      = 1'b0;
                end else begin
                    shift_d = {shift_q[DATA_W-1:0], bus.MOSI};
                    if (cnt_q == CNT_LAST_RX) begin
                        cnt_d      = CNT_FULL;
                        rx_data_d  = {shift_q, bus.MOSI};
                        rx_valid_d = 1'b1;
                        if (state_q == READ_ADDR) begin
                            rd_addr_seen_d = 1'b1;
                            state_d        = DONE;
                        end else if (state_q == READ_DATA) begin
                            rd_addr_seen_d = 1'b0;
                            state_d        = TX_WAIT;
                        end else begin
                            state_d = DONE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end

            TX_WAIT: begin
                if (bus.SS_n) begin
                    state_d = IDLE;
                    miso_d  = 1'b0;
                end else if (bus.tx_valid) begin
                    // MSB goes out now; the register keeps the remainder
                    // left-aligned so its top bit is always the next one.
                    miso_d  = bus.tx_data[DATA_W-1];
                    tx_sh_d = {bus.tx_data[DATA_W-2:0], 1'b0};
                    cnt_d   = CNT_ONE;
                    state_d = TX_SHIFT;
                end
            end

            TX_SHIFT: begin
                if (bus.SS_n) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                    miso_d      = 1'b0;
                end else if (cnt_q == CNT_LAST_TX) begin
                    miso_d  = 1'b0;
                    state_d = DONE;
                end else begin
                    miso_d  = tx_sh_q[DATA_W-1];
                    tx_sh_d = {tx_sh_q[DATA_W-2:0], 1'b0};
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end

            DONE: begin
                miso_d = 1'b0;
                if (bus.SS_n) state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                miso_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: the reset branch covers every flop, including the MISO bit being shifted.
        if (!rstn) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            shift_q        <= '0;
            tx_sh_q        <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            frame_err_q    <= 1'b0;
            miso_q         <= 1'b0;
            rd_addr_seen_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            shift_q        <= shift_d;
            tx_sh_q        <= tx_sh_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            frame_err_q    <= frame_err_d;
            miso_q         <= miso_d;
            rd_addr_seen_q <= rd_addr_seen_d;
        end
    end

    assign bus.MISO      = miso_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.rx_data   = rx_data_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_spi_slave_param.sv
// ---------------------------------------------------------------------------
// tb_spi_slave_param
//   Directed and randomised frames against an 8-bit and a 16-bit instance.
//   The reference model tracks only the externally visible rules: the last
//   completed frame, whether a read address has been seen, and which frames
//   lead to a transmit.
// ---------------------------------------------------------------------------
module tb_spi_slave_param;

    logic clk;
    logic rstn;

    spi_slave_param_if #(.DATA_W(8))  bus8 ();
    spi_slave_param_if #(.DATA_W(16)) bus16 ();

    spi_slave_param #(.DATA_W(8))  dut8  (.clk(clk), .rstn(rstn), .bus(bus8));
    spi_slave_param #(.DATA_W(16)) dut16 (.clk(clk), .rstn(rstn), .bus(bus16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [9:0]  rx_exp8;
    logic [17:0] rx_exp16;
    logic        rd_seen_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sends one frame; abort_at = number of bits captured before SS_n rises
    // (-1 for none). kind: 0 = complete, no transmit; 1 = complete, transmit
    // expected; 2 = aborted.
    task automatic frame8(input logic [9:0] f, input int abort_at, output int kind);
        bus8.tx_valid = 1'b0;
        bus8.SS_n     = 1'b0;
        step();
        check("busy_start", bus8.busy, 1'b1);
        for (int i = 0; i < 10; i++) begin
            if (i == abort_at) begin
                bus8.SS_n = 1'b1;
                step();
                check("abort_err",     bus8.frame_err, 1'b1);
                check("abort_busy",    bus8.busy,      1'b0);
                check("abort_rxvalid", bus8.rx_valid,  1'b0);
                check("abort_rxdata",  bus8.rx_data,   rx_exp8);
                check("abort_miso",    bus8.MISO,      1'b0);
                step();
                check("abort_err_pulse", bus8.frame_err, 1'b0);
                kind = 2;
                return;
            end
            bus8.MOSI = f[9-i];
            step();
            check("rx_valid", bus8.rx_valid, (i == 9));
        end
        check("rx_data", bus8.rx_data, f);
        rx_exp8 = f;
        if (!f[9]) begin
            kind = 0;
        end else if (!rd_seen_m) begin
            rd_seen_m = 1'b1;
            kind      = 0;
        end else begin
            rd_seen_m = 1'b0;
            kind      = 1;
        end
    endtask

    // DONE: MOSI and tx_valid must be ignored, MISO stays 0.
    task automatic done8();
        bus8.tx_valid = 1'b1;
        bus8.tx_data  = 8'($urandom);
        for (int i = 0; i < 2; i++) begin
            bus8.MOSI = 1'($urandom);
            step();
            check("done_miso",    bus8.MISO,     1'b0);
            check("done_busy",    bus8.busy,     1'b1);
            check("done_rxvalid", bus8.rx_valid, 1'b0);
        end
        bus8.tx_valid = 1'b0;
    endtask

    // Transmit phase; abort_bits = bits shown on MISO before SS_n rises (-1 none).
    task automatic tx8(input logic [7:0] d, input int delay, input int abort_bits);
        bus8.tx_valid = 1'b0;
        for (int i = 0; i < delay; i++) begin
            bus8.tx_data = 8'($urandom);
            step();
            check("wait_miso", bus8.MISO, 1'b0);
            check("wait_rxvalid", bus8.rx_valid, 1'b0);
        end
        bus8.tx_valid = 1'b1;
        bus8.tx_data  = d;
        for (int k = 0; k < 8; k++) begin
            step();
            // tx_valid stays high with different data: a reload would show up.
            bus8.tx_data = ~d;
            check("miso_bit", bus8.MISO, d[7-k]);
            check("tx_rxvalid", bus8.rx_valid, 1'b0);
            if (k + 1 == abort_bits) begin
                bus8.SS_n = 1'b1;
                step();
                check("txabort_err",  bus8.frame_err, 1'b1);
                check("txabort_miso", bus8.MISO,      1'b0);
                check("txabort_busy", bus8.busy,      1'b0);
                bus8.tx_valid = 1'b0;
                return;
            end
        end
        step();
        check("miso_end", bus8.MISO, 1'b0);
        check("tx_busy",  bus8.busy, 1'b1);
        bus8.tx_valid = 1'b0;
    endtask

    task automatic end8();
        bus8.SS_n     = 1'b1;
        bus8.tx_valid = 1'b0;
        step();
        check("end_busy", bus8.busy,      1'b0);
        check("end_err",  bus8.frame_err, 1'b0);
        check("end_miso", bus8.MISO,      1'b0);
    endtask

    task automatic transact8(input logic [9:0] f, input int abort_at,
                             input logic [7:0] d, input int delay, input int tx_abort);
        int kind;
        frame8(f, abort_at, kind);
        if (kind == 1)      tx8(d, delay, tx_abort);
        else if (kind == 0) done8();
        end8();
    endtask

    task automatic frame16(input logic [17:0] f);
        bus16.SS_n = 1'b0;
        step();
        for (int i = 0; i < 18; i++) begin
            bus16.MOSI = f[17-i];
            step();
            check("rx_valid16", bus16.rx_valid, (i == 17));
        end
        check("rx_data16", bus16.rx_data, f);
        rx_exp16 = f;
        step();
        check("rx_valid16_pulse", bus16.rx_valid, 1'b0);
        check("busy16_done", bus16.busy, 1'b1);
        bus16.SS_n = 1'b1;
        step();
        check("busy16_end", bus16.busy, 1'b0);
        check("rx_data16_hold", bus16.rx_data, rx_exp16);
    endtask

    initial begin
        int kind;
        rx_exp8   = '0;
        rx_exp16  = '0;
        rd_seen_m = 1'b0;
        rstn      = 1'b0;
        bus8.MOSI = 1'b0;  bus8.SS_n  = 1'b1;  bus8.tx_data  = '0; bus8.tx_valid  = 1'b0;
        bus16.MOSI = 1'b0; bus16.SS_n = 1'b1;  bus16.tx_data = '0; bus16.tx_valid = 1'b0;

        // Reset state
        step();
        step();
        check("rst_miso",     bus8.MISO,      1'b0);
        check("rst_rxvalid",  bus8.rx_valid,  1'b0);
        check("rst_rxdata",   bus8.rx_data,   10'h000);
        check("rst_err",      bus8.frame_err, 1'b0);
        check("rst_busy",     bus8.busy,      1'b0);
        check("rst_rxdata16", bus16.rx_data,  18'h0);
        check("rst_busy16",   bus16.busy,     1'b0);
        rstn = 1'b1;
        step();

        // Write address 0A5
        transact8(10'h0A5, -1, 8'h00, 0, -1);
        // Read address then read data with C3
        transact8(10'h203, -1, 8'h00, 0, -1);
        transact8(10'h300, -1, 8'hC3, 0, -1);
        // rd_addr_seen cleared: next read frame is an address again (no transmit)
        transact8(10'h2AA, -1, 8'h00, 0, -1);
        // Read data with tx_valid delayed 10 cycles
        transact8(10'h355, -1, 8'($urandom), 10, -1);
        // Write frame aborted after 5 captured bits
        transact8(10'h0F3, 5, 8'h00, 0, -1);
        // Aborted transmit after 4 bits
        transact8(10'h211, -1, 8'h00, 0, -1);
        transact8(10'h3A0, -1, 8'h96, 0, 4);

        // Reset during TX_SHIFT after 3 bits
        frame8(10'h240, -1, kind);
        bus8.SS_n = 1'b1;
        step();
        frame8(10'h3C0, -1, kind);
        check("rst_test_kind", kind, 1);
        bus8.tx_valid = 1'b1;
        bus8.tx_data  = 8'hE5;
        for (int k = 0; k < 3; k++) begin
            step();
            check("rst_test_bit", bus8.MISO, (8'hE5 >> (7 - k)) & 1);
        end
        #2;
        rstn = 1'b0;
        #1;
        check("midrst_miso",    bus8.MISO,     1'b0);
        check("midrst_busy",    bus8.busy,     1'b0);
        check("midrst_rxdata",  bus8.rx_data,  10'h000);
        check("midrst_rxvalid", bus8.rx_valid, 1'b0);
        rx_exp8   = '0;
        rd_seen_m = 1'b0;
        bus8.SS_n     = 1'b1;
        bus8.tx_valid = 1'b0;
        step();
        rstn = 1'b1;
        step();
        transact8(10'h1F0, -1, 8'h00, 0, -1);
        // rd_addr_seen was cleared by reset: this read frame must not transmit
        transact8(10'h3FF, -1, 8'h00, 0, -1);

        // Randomised frames
        for (int n = 0; n < 24; n++) begin
            logic [9:0] f;
            int ab, txab;
            f    = 10'($urandom);
            ab   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 9)) : -1;
            txab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 7)) : -1;
            transact8(f, ab, 8'($urandom), int'($urandom_range(0, 3)), txab);
        end

        // 16-bit instance
        frame16(18'h1BEEF);
        frame16({2'b0, 1'($urandom), 15'($urandom)});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
